// File: rtl/load_store_unit.sv
// Memory-access stage between the datapath and a 128-byte big-endian data memory.
// Handles one request at a time; byte stores use read-modify-write because the memory writes 16 bits.
module load_store_unit #(
  parameter int MEM_BYTES  = 128,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic                  req_byte_i,
  input  logic                  req_signed_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [15:0]           req_wdata_i,
  output logic                  resp_valid_o,
  output logic [15:0]           resp_rdata_o,
  output logic                  resp_fault_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic [15:0]           mem_write_data_o,
  output logic                  mem_write_o,
  output logic                  mem_read_o,
  input  logic [15:0]           mem_read_data_i
);

  localparam logic [ADDR_WIDTH-1:0] WORD_MAX = ADDR_WIDTH'(MEM_BYTES - 2);
  localparam logic [ADDR_WIDTH-1:0] BYTE_MAX = ADDR_WIDTH'(MEM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP
  } state_t;

  state_t                  state_q;
  logic                    byte_q, signed_q, lane_q;
  logic [7:0]              bdata_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [15:0]             mem_wdata_q;
  logic                    mem_rd_q, mem_wr_q;
  logic                    resp_valid_q, resp_fault_q;
  logic [15:0]             rdata_q;

  logic                    req_fault_d;
  logic [ADDR_WIDTH-1:0]   req_base_d;
  logic [7:0]              lane_byte_d;
  logic [15:0]             load_data_d;
  logic [15:0]             merged_d;

  always_comb begin
    req_base_d  = {req_addr_i[ADDR_WIDTH-1:1], 1'b0};
    req_fault_d = req_byte_i ? (req_addr_i > BYTE_MAX)
                             : (req_addr_i[0] || (req_addr_i > WORD_MAX));
    // Big-endian: lane 0 is the high byte of the word
    lane_byte_d = lane_q ? mem_read_data_i[7:0] : mem_read_data_i[15:8];
    load_data_d = byte_q ? {{8{signed_q & lane_byte_d[7]}}, lane_byte_d} : mem_read_data_i;
    merged_d    = lane_q ? {mem_read_data_i[15:8], bdata_q} : {bdata_q, mem_read_data_i[7:0]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      byte_q       <= 1'b0;
      signed_q     <= 1'b0;
      lane_q       <= 1'b0;
      bdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            byte_q   <= req_byte_i;
            signed_q <= req_signed_i;
            lane_q   <= req_addr_i[0];
            bdata_q  <= req_wdata_i[7:0];
            if (req_fault_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              rdata_q      <= '0;
            end else if (!req_write_i) begin
              state_q    <= LOAD;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= req_byte_i ? req_base_d : req_addr_i;
            end else if (!req_byte_i) begin
              state_q     <= STORE;
              mem_wr_q    <= 1'b1;
              mem_addr_q  <= req_addr_i;
              mem_wdata_q <= req_wdata_i;
            end else begin
              state_q    <= RMW_RD;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= req_base_d;
            end
          end
        end
        LOAD: begin
          state_q      <= RESP;
          mem_rd_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b0;
          rdata_q      <= load_data_d;
        end
        STORE: begin
          state_q      <= RESP;
          mem_wr_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b0;
          rdata_q      <= '0;
        end
        RMW_RD: begin
          state_q     <= RMW_WR;
          mem_rd_q    <= 1'b0;
          mem_wr_q    <= 1'b1;
          mem_wdata_q <= merged_d;
        end
        RMW_WR: begin
          state_q      <= RESP;
          mem_wr_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b0;
          rdata_q      <= '0;
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_fault_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gating with reset keeps an interrupted store from committing and holds every output low in reset
  assign req_ready_o      = (state_q == IDLE) & ~rst_i;
  assign resp_valid_o     = resp_valid_q & ~rst_i;
  assign resp_fault_o     = resp_fault_q & ~rst_i;
  assign resp_rdata_o     = rdata_q & {16{~rst_i}};
  assign mem_address_o    = mem_addr_q & {ADDR_WIDTH{~rst_i}};
  assign mem_write_data_o = mem_wdata_q & {16{~rst_i}};
  assign mem_write_o      = mem_wr_q & ~rst_i;
  assign mem_read_o       = mem_rd_q & ~rst_i;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 128-byte big-endian memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, rv, rw, rb, rs;
  logic [15:0] ra, rwd;
  logic        req_ready_o, resp_valid_o, resp_fault_o, mem_write_o, mem_read_o;
  logic [15:0] resp_rdata_o, mem_address_o, mem_write_data_o, mem_read_data_i;

  logic [7:0]  mem [128];
  logic        mem_clr;
  int          wr_cnt = 0, rd_cnt = 0, wr0, rd0, lat;
  logic [15:0] rd_addr;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv), .req_ready_o(req_ready_o),
    .req_write_i(rw), .req_byte_i(rb), .req_signed_i(rs), .req_addr_i(ra),
    .req_wdata_i(rwd), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .resp_fault_o(resp_fault_o), .mem_address_o(mem_address_o),
    .mem_write_data_o(mem_write_data_o), .mem_write_o(mem_write_o),
    .mem_read_o(mem_read_o), .mem_read_data_i(mem_read_data_i)
  );

  assign mem_read_data_i = {mem[mem_address_o[6:0]], mem[mem_address_o[6:0] + 7'd1]};

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
    end else if (mem_write_o) begin
      mem[mem_address_o[6:0]]         <= mem_write_data_o[15:8];
      mem[mem_address_o[6:0] + 7'd1]  <= mem_write_data_o[7:0];
    end
    if (mem_write_o) wr_cnt <= wr_cnt + 1;
    if (mem_read_o) begin
      rd_cnt  <= rd_cnt + 1;
      rd_addr <= mem_address_o;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request, wait for ready (bounded), take the accept edge.
  task automatic issue(input logic w, input logic b, input logic s,
                       input logic [15:0] a, input logic [15:0] d, input logic keep);
    int n;
    rw = w; rb = b; rs = s; ra = a; rwd = d; rv = 1'b1;
    n = 0;
    while (!req_ready_o && n < 20) begin tick(); n++; end
    chk("ready_before_accept", {31'd0, req_ready_o}, 32'd1);
    wr0 = wr_cnt; rd0 = rd_cnt;
    tick();
    if (!keep) rv = 1'b0;
  endtask

  // Returns edges from accept to the cycle RespValid is seen high (accept edge counts as 1).
  task automatic wait_resp(output int l);
    l = 1;
    while (!resp_valid_o && l < 12) begin tick(); l++; end
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1; rv = 1'b0; rw = 1'b0; rb = 1'b0; rs = 1'b0;
    ra = 16'h0; rwd = 16'h0;
    tick(); tick(); tick();
    chk("rst_ready",  {31'd0, req_ready_o},  32'd0);
    chk("rst_rvalid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_mwrite", {31'd0, mem_write_o},  32'd0);
    chk("rst_rdata",  {16'd0, resp_rdata_o}, 32'd0);
    rst = 1'b0; mem_clr = 1'b0;
    #1;
    chk("idle_ready", {31'd0, req_ready_o}, 32'd1);

    // Word store then word load
    issue(1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234, 1'b0);
    wait_resp(lat);
    chk("wst_lat",   lat, 2);
    chk("wst_fault", {31'd0, resp_fault_o}, 32'd0);
    chk("wst_rdata", {16'd0, resp_rdata_o}, 32'd0);
    tick();
    chk("wst_mem10", {24'd0, mem[8'h10]}, 32'h12);
    chk("wst_mem11", {24'd0, mem[8'h11]}, 32'h34);
    chk("wst_writes", wr_cnt - wr0, 1);

    issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0);
    wait_resp(lat);
    chk("wld_lat",   lat, 2);
    chk("wld_rdata", {16'd0, resp_rdata_o}, 32'h1234);
    tick();
    chk("wld_reads", rd_cnt - rd0, 1);

    // Byte store into low lane
    issue(1'b1, 1'b1, 1'b0, 16'h0011, 16'h77AB, 1'b0);
    wait_resp(lat);
    chk("bst_lat", lat, 3);
    tick();
    chk("bst_mem10", {24'd0, mem[8'h10]}, 32'h12);
    chk("bst_mem11", {24'd0, mem[8'h11]}, 32'hAB);
    chk("bst_writes", wr_cnt - wr0, 1);
    chk("bst_reads",  rd_cnt - rd0, 1);

    issue(1'b1, 1'b1, 1'b0, 16'h0011, 16'h0080, 1'b0);
    wait_resp(lat);
    tick();
    chk("bst80_mem11", {24'd0, mem[8'h11]}, 32'h80);

    // Byte loads: sign/zero extension and lane select
    issue(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, 1'b0);
    wait_resp(lat);
    chk("bld_s_lat",   lat, 2);
    chk("bld_s_rdata", {16'd0, resp_rdata_o}, 32'hFF80);
    tick();
    issue(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0);
    wait_resp(lat);
    chk("bld_u_rdata", {16'd0, resp_rdata_o}, 32'h0080);
    tick();
    issue(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 1'b0);
    wait_resp(lat);
    chk("bld_hi_rdata", {16'd0, resp_rdata_o}, 32'h0012);
    tick();

    // Highest legal word, then byte load from the last byte
    issue(1'b1, 1'b0, 1'b0, 16'h007E, 16'hCAFE, 1'b0);
    wait_resp(lat);
    chk("w7e_fault", {31'd0, resp_fault_o}, 32'd0);
    tick();
    chk("w7e_mem7e", {24'd0, mem[8'h7E]}, 32'hCA);
    chk("w7e_mem7f", {24'd0, mem[8'h7F]}, 32'hFE);
    issue(1'b0, 1'b1, 1'b0, 16'h007F, 16'h0000, 1'b0);
    wait_resp(lat);
    chk("b7f_rdata", {16'd0, resp_rdata_o}, 32'h00FE);
    chk("b7f_addr",  {16'd0, rd_addr}, 32'h007E);
    tick();

    // Faults: misaligned word, word past end, byte past end
    issue(1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, 1'b0);
    wait_resp(lat);
    chk("f11_lat",   lat, 1);
    chk("f11_fault", {31'd0, resp_fault_o}, 32'd1);
    chk("f11_rdata", {16'd0, resp_rdata_o}, 32'd0);
    tick();
    chk("f11_reads", rd_cnt - rd0, 0);
    issue(1'b1, 1'b0, 1'b0, 16'h007F, 16'h5555, 1'b0);
    wait_resp(lat);
    chk("f7f_lat",   lat, 1);
    chk("f7f_fault", {31'd0, resp_fault_o}, 32'd1);
    tick();
    chk("f7f_writes", wr_cnt - wr0, 0);
    chk("f7f_mem7e",  {24'd0, mem[8'h7E]}, 32'hCA);
    issue(1'b1, 1'b1, 1'b0, 16'h0080, 16'h0011, 1'b0);
    wait_resp(lat);
    chk("f80_lat",   lat, 1);
    chk("f80_fault", {31'd0, resp_fault_o}, 32'd1);
    tick();
    chk("f80_rw", (wr_cnt - wr0) + (rd_cnt - rd0), 0);

    // Reset arrives while a store is in flight
    issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0);
    wait_resp(lat);
    tick();
    issue(1'b1, 1'b0, 1'b0, 16'h0020, 16'hBEEF, 1'b0);
    chk("rst_store_live", {31'd0, mem_write_o}, 32'd1);
    rst = 1'b1; #1;
    chk("rst_mw_gated", {31'd0, mem_write_o}, 32'd0);
    chk("rst_ready_lo", {31'd0, req_ready_o}, 32'd0);
    tick();
    chk("rst_no_resp", {31'd0, resp_valid_o}, 32'd0);
    rst = 1'b0; #1;
    chk("rst_ready_hi", {31'd0, req_ready_o}, 32'd1);
    chk("rst_rdata_clr", {16'd0, resp_rdata_o}, 32'd0);
    tick();
    chk("rst_no_resp2", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_mem20", {16'd0, mem[8'h20], mem[8'h21]}, 32'd0);

    // Valid held high with fields changing while busy
    issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1);
    rb = 1'b1; ra = 16'h0011; rs = 1'b0;
    chk("hold_busy", {31'd0, req_ready_o}, 32'd0);
    wait_resp(lat);
    chk("hold_lat1",  lat, 2);
    chk("hold_rdata1", {16'd0, resp_rdata_o}, 32'h1280);
    chk("hold_resp_ready", {31'd0, req_ready_o}, 32'd0);
    tick();
    chk("hold_idle_ready", {31'd0, req_ready_o}, 32'd1);
    rs = 1'b1;
    tick();
    rv = 1'b0;
    wait_resp(lat);
    chk("hold_lat2",  lat, 2);
    chk("hold_rdata2", {16'd0, resp_rdata_o}, 32'hFF80);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
